fir_multich_mac: RTL

//   Parametrised serial-MAC FIR filter, successor to the fixed 31-tap filter.

---
 rtl/fir_multich_mac.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/fir_multich_mac.sv
// Multi-channel serial-MAC FIR filter: runtime-loadable shared coefficients, one delay line per channel.
// Define FIR_SAT_EN to clamp y to the output range and add the sat flag; by default y wraps.
module fir_multich_mac #(
    parameter int TAPS = 31,
    parameter int DW   = 8,
    parameter int CW   = 10,
    parameter int YW   = 18,
    parameter int NCH  = 2,
    localparam int KW  = $clog2(TAPS),
    localparam int AW  = DW + CW + $clog2(TAPS),
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CHW-1:0]       ch,
    input  logic signed [DW-1:0] x,
    input  logic                 coef_we,
    input  logic [KW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic                 busy,
    output logic                 done,
    output logic signed [YW-1:0] y,
`ifdef FIR_SAT_EN
    output logic                 sat,
`endif
    output logic [CHW-1:0]       y_ch
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic signed [CW-1:0] coef_q [TAPS];
    logic signed [DW-1:0] ring_q [NCH][TAPS];
    logic [KW-1:0]        wptr_q [NCH];

    logic signed [AW-1:0] acc_q, acc_d;
    logic [KW-1:0]        k_q, k_d;
    logic [CHW-1:0]       ch_q, ch_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic signed [YW-1:0] y_q, y_d;
    logic [CHW-1:0]       ych_q, ych_d;

    logic                 accept;
    logic                 coef_wr;
    logic                 wptr_adv;
    logic [KW-1:0]        wptr_cur;
    logic [KW:0]          diff;
    logic [KW-1:0]        rd_idx;
    logic signed [DW+CW-1:0] product;
    logic signed [AW-1:0] acc_sum;
    logic signed [YW-1:0] y_red;

`ifdef FIR_SAT_EN
    logic sat_q, sat_d;
    logic sat_red;
`endif

    always_comb begin
        accept   = (state_q == S_IDLE) && start && (int'(ch) < NCH);
        coef_wr  = (state_q == S_IDLE) && coef_we && (int'(coef_addr) < TAPS);
        wptr_cur = wptr_q[ch_q];
        // Ring read position (wptr - k) mod TAPS, with one guard bit for the borrow.
        diff     = {1'b0, wptr_cur} - {1'b0, k_q};
        if (diff[KW]) begin
            diff = diff + (KW+1)'(TAPS);
        end
        rd_idx   = diff[KW-1:0];
        product  = ring_q[ch_q][rd_idx] * coef_q[k_q];
        acc_sum  = acc_q + {{(AW-DW-CW){product[DW+CW-1]}}, product};
    end

    generate
        if (YW >= AW) begin : g_wide
            assign y_red = YW'(acc_q);
`ifdef FIR_SAT_EN
            assign sat_red = 1'b0;
`endif
        end else begin : g_narrow
`ifdef FIR_SAT_EN
            localparam logic signed [AW-1:0] YMAX = {{(AW-YW+1){1'b0}}, {(YW-1){1'b1}}};
            localparam logic signed [AW-1:0] YMIN = {{(AW-YW+1){1'b1}}, {(YW-1){1'b0}}};
            assign sat_red = (acc_q > YMAX) || (acc_q < YMIN);
            assign y_red   = (acc_q > YMAX) ? YMAX[YW-1:0] :
                             (acc_q < YMIN) ? YMIN[YW-1:0] : acc_q[YW-1:0];
`else
            assign y_red = acc_q[YW-1:0];
`endif
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        k_d      = k_q;
        ch_d     = ch_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        y_d      = y_q;
        ych_d    = ych_q;
        wptr_adv = 1'b0;
`ifdef FIR_SAT_EN
        sat_d    = sat_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d   = '0;
                    k_d     = '0;
                    ch_d    = ch;
                    busy_d  = 1'b1;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_sum;
                if (k_q == KW'(TAPS-1)) begin
                    state_d = S_OUT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_OUT: begin
                y_d      = y_red;
                ych_d    = ch_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                wptr_adv = 1'b1;
`ifdef FIR_SAT_EN
                sat_d    = sat_red;
`endif
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            k_q     <= '0;
            ch_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
            ych_q   <= '0;
`ifdef FIR_SAT_EN
            sat_q   <= 1'b0;
`endif
            for (int unsigned t = 0; t < TAPS; t++) begin
                coef_q[t] <= '0;
            end
            for (int unsigned n = 0; n < NCH; n++) begin
                wptr_q[n] <= '0;
                for (int unsigned t = 0; t < TAPS; t++) begin
                    ring_q[n][t] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            ch_q    <= ch_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            y_q     <= y_d;
            ych_q   <= ych_d;
`ifdef FIR_SAT_EN
            sat_q   <= sat_d;
`endif
            if (coef_wr) begin
                coef_q[coef_addr] <= coef_data;
            end
            if (accept) begin
                ring_q[ch][wptr_q[ch]] <= x;
            end
            if (wptr_adv) begin
                wptr_q[ch_q] <= (wptr_q[ch_q] == KW'(TAPS-1)) ? '0 : wptr_q[ch_q] + 1'b1;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y    = y_q;
    assign y_ch = ych_q;
`ifdef FIR_SAT_EN
    assign sat  = sat_q;
`endif

endmodule
